// File: rtl/rec_fn_pkg.sv
// Shared constants, raw-float bundle and fclass helper for
// single-precision recoded-float (recFN) handling.
package rec_fn_pkg;

    localparam int EXP_W        = 8;
    localparam int SIG_W        = 24;
    localparam int REC_W        = EXP_W + SIG_W + 1;
    localparam int MIN_NORM_EXP = 130;
    localparam int EXP_BIAS_ADJ = 129;

    localparam logic [2:0] CODE_ZERO = 3'b000;
    localparam logic [2:0] CODE_INF  = 3'b110;
    localparam logic [2:0] CODE_NAN  = 3'b111;

    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;

    typedef struct packed {
        logic               isNaN;
        logic               isInf;
        logic               isZero;
        logic               sign;
        logic [EXP_W+1:0]   sExp;
        logic [SIG_W+2:0]   sig;
    } raw_float_t;

    // sig[24] is the top fraction bit, which splits quiet from signalling NaN
    function automatic logic [9:0] fclass_mask(input raw_float_t r,
                                               input logic is_sub);
        logic [9:0] m;
        m = '0;
        unique case (1'b1)
            r.isNaN:  m[r.sig[24] ? CLS_QNAN : CLS_SNAN] = 1'b1;
            r.isInf:  m[r.sign ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
            r.isZero: m[r.sign ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
            is_sub:   m[r.sign ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
            default:  m[r.sign ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/rec_fn_unpack_pipe_decode.sv
// Combinational recFN decode: raw fields, subnormal flag and the
// saturated right-shift distance used to denormalise the fraction.
import rec_fn_pkg::*;

module rec_fn_decode (
    input  logic [REC_W-1:0] i_rec,
    output raw_float_t       o_raw,
    output logic             o_is_sub,
    output logic [4:0]       o_shift
);

    logic             w_sign;
    logic [EXP_W:0]   w_exp;
    logic [SIG_W-2:0] w_fract;
    logic [2:0]       w_code;
    logic             w_zero;
    logic             w_inf;
    logic             w_nan;
    logic [EXP_W:0]   w_dist;

    assign w_sign  = i_rec[REC_W-1];
    assign w_exp   = i_rec[REC_W-2:SIG_W-1];
    assign w_fract = i_rec[SIG_W-2:0];
    assign w_code  = w_exp[EXP_W:EXP_W-2];

    assign w_zero = (w_code == CODE_ZERO);
    assign w_inf  = (w_code == CODE_INF);
    assign w_nan  = (w_code == CODE_NAN);

    assign o_raw.isNaN  = w_nan;
    assign o_raw.isInf  = w_inf;
    assign o_raw.isZero = w_zero;
    assign o_raw.sign   = w_sign;
    assign o_raw.sExp   = {1'b0, w_exp};
    assign o_raw.sig    = {1'b0, !w_zero, w_fract, 2'b00};

    assign o_is_sub = !(w_zero | w_inf | w_nan)
                    && (w_exp < 9'(MIN_NORM_EXP));
    assign w_dist   = 9'(MIN_NORM_EXP) - w_exp;

    // Exponents down to 64 are encodable, so clamp rather than wrap
    assign o_shift = !o_is_sub          ? 5'd0
                   : (w_dist >= 9'd24)  ? 5'd24
                   : w_dist[4:0];

endmodule

// File: rtl/rec_fn_unpack_pipe.sv
// Two-stage recFN unpack pipeline: decode in stage 1, IEEE pack and
// fclass in stage 2, with a valid/ready handshake on both sides.
import rec_fn_pkg::*;

module rec_fn_unpack_pipe (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [REC_W-1:0] io_in_rec,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic             io_out_isNaN,
    output logic             io_out_isInf,
    output logic             io_out_isZero,
    output logic             io_out_sign,
    output logic [9:0]       io_out_sExp,
    output logic [26:0]      io_out_sig,
    output logic [31:0]      io_out_ieee,
    output logic [9:0]       io_out_class
);

    raw_float_t  w_dec_raw;
    logic        w_dec_sub;
    logic [4:0]  w_dec_shift;

    logic        r_s1_valid;
    raw_float_t  r_s1_raw;
    logic        r_s1_sub;
    logic [4:0]  r_s1_shift;

    logic        r_s2_valid;
    raw_float_t  r_s2_raw;
    logic [31:0] r_s2_ieee;
    logic [9:0]  r_s2_class;

    logic        w_s2_load;
    logic        w_in_fire;
    logic [22:0] w_fract;
    logic [22:0] w_sub_frac;
    logic [7:0]  w_norm_exp;
    logic [31:0] w_ieee;

    rec_fn_decode u_decode (
        .i_rec    (io_in_rec),
        .o_raw    (w_dec_raw),
        .o_is_sub (w_dec_sub),
        .o_shift  (w_dec_shift)
    );

    assign w_s2_load   = !r_s2_valid | io_out_ready;
    assign io_in_ready = !r_s1_valid | w_s2_load;
    assign w_in_fire   = io_in_valid & io_in_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_raw   <= '0;
            r_s1_sub   <= 1'b0;
            r_s1_shift <= '0;
        end else begin
            if (io_in_ready)
                r_s1_valid <= w_in_fire;
            if (w_in_fire) begin
                r_s1_raw   <= w_dec_raw;
                r_s1_sub   <= w_dec_sub;
                r_s1_shift <= w_dec_shift;
            end
        end
    end

    assign w_fract    = r_s1_raw.sig[24:2];
    assign w_sub_frac = 23'({1'b1, w_fract} >> r_s1_shift);
    assign w_norm_exp = 8'(r_s1_raw.sExp - 10'(EXP_BIAS_ADJ));

    always_comb begin
        w_ieee = {r_s1_raw.sign, 31'b0};
        unique case (1'b1)
            r_s1_raw.isZero: w_ieee = {r_s1_raw.sign, 31'b0};
            r_s1_raw.isInf:  w_ieee = {r_s1_raw.sign, 8'hFF, 23'b0};
            r_s1_raw.isNaN:  w_ieee = {r_s1_raw.sign, 8'hFF, w_fract};
            r_s1_sub:        w_ieee = {r_s1_raw.sign, 8'h00, w_sub_frac};
            default:         w_ieee = {r_s1_raw.sign, w_norm_exp, w_fract};
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_raw   <= '0;
            r_s2_ieee  <= '0;
            r_s2_class <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_raw   <= r_s1_raw;
                r_s2_ieee  <= w_ieee;
                r_s2_class <= fclass_mask(r_s1_raw, r_s1_sub);
            end
        end
    end

    assign io_out_valid  = r_s2_valid;
    assign io_out_isNaN  = r_s2_raw.isNaN;
    assign io_out_isInf  = r_s2_raw.isInf;
    assign io_out_isZero = r_s2_raw.isZero;
    assign io_out_sign   = r_s2_raw.sign;
    assign io_out_sExp   = r_s2_raw.sExp;
    assign io_out_sig    = r_s2_raw.sig;
    assign io_out_ieee   = r_s2_ieee;
    assign io_out_class  = r_s2_class;

endmodule

// File: tb/tb_rec_fn_unpack_pipe.sv
// Directed self-checking bench for rec_fn_unpack_pipe.
// Inputs change and outputs are sampled on the falling edge.
module tb_rec_fn_unpack_pipe;

    logic        clock;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [32:0] io_in_rec;
    logic        io_out_valid;
    logic        io_out_ready;
    logic        io_out_isNaN;
    logic        io_out_isInf;
    logic        io_out_isZero;
    logic        io_out_sign;
    logic [9:0]  io_out_sExp;
    logic [26:0] io_out_sig;
    logic [31:0] io_out_ieee;
    logic [9:0]  io_out_class;

    int checks   = 0;
    int failures = 0;

    rec_fn_unpack_pipe dut (
        .clock         (clock),
        .reset         (reset),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_rec     (io_in_rec),
        .io_out_valid  (io_out_valid),
        .io_out_ready  (io_out_ready),
        .io_out_isNaN  (io_out_isNaN),
        .io_out_isInf  (io_out_isInf),
        .io_out_isZero (io_out_isZero),
        .io_out_sign   (io_out_sign),
        .io_out_sExp   (io_out_sExp),
        .io_out_sig    (io_out_sig),
        .io_out_ieee   (io_out_ieee),
        .io_out_class  (io_out_class)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Push one word into an idle pipe; returns when it is on the outputs
    task automatic run_word(input logic [32:0] rec);
        @(negedge clock);
        io_out_ready = 1'b1;
        io_in_valid  = 1'b1;
        io_in_rec    = rec;
        @(negedge clock);
        io_in_valid  = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_in_rec    = '0;
        io_out_ready = 1'b0;
        #3;
        checks++;
        if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hs: valid=%b ready=%b want 0/1",
                     io_out_valid, io_in_ready);
        end
        checks++;
        if (io_out_ieee !== 32'h0 || io_out_class !== 10'h0
            || io_out_sExp !== 10'h0 || io_out_sig !== 27'h0) begin
            failures++;
            $display("FAIL reset_data: ieee=%h class=%h want 0/0",
                     io_out_ieee, io_out_class);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_latency;
        @(negedge clock);
        io_out_ready = 1'b1;
        io_in_valid  = 1'b1;
        io_in_rec    = 33'h0_8000_0000;
        #1;
        checks++;
        if (io_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL lat_ready: got %b want 1", io_in_ready);
        end
        @(negedge clock);
        io_in_valid = 1'b0;
        checks++;
        if (io_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_early: valid=%b want 0", io_out_valid);
        end
        @(negedge clock);
        checks++;
        if (io_out_valid !== 1'b1 || io_out_ieee !== 32'h3F80_0000) begin
            failures++;
            $display("FAIL lat_2cyc: valid=%b ieee=%h want 1/3f800000",
                     io_out_valid, io_out_ieee);
        end
        checks++;
        if (io_out_sExp !== 10'h100 || io_out_sig !== 27'h200_0000
            || io_out_class !== 10'h040) begin
            failures++;
            $display("FAIL one_raw: sExp=%h sig=%h class=%h want 100/2000000/040",
                     io_out_sExp, io_out_sig, io_out_class);
        end
        checks++;
        if ({io_out_isNaN, io_out_isInf, io_out_isZero, io_out_sign} !== 4'b0000) begin
            failures++;
            $display("FAIL one_flags: got %b want 0000",
                     {io_out_isNaN, io_out_isInf, io_out_isZero, io_out_sign});
        end
    endtask

    task automatic test_normal;
        logic [32:0] rec  [4] = '{33'h0_8080_0000, 33'h0_BFFF_FFFF,
                                  33'h1_8000_0000, 33'h0_4100_0000};
        logic [31:0] ieee [4] = '{32'h4000_0000, 32'h7F7F_FFFF,
                                  32'hBF80_0000, 32'h0080_0000};
        logic [9:0]  cls  [4] = '{10'h040, 10'h040, 10'h002, 10'h040};
        for (int i = 0; i < 4; i++) begin
            run_word(rec[i]);
            checks++;
            if (io_out_valid !== 1'b1 || io_out_ieee !== ieee[i]
                || io_out_class !== cls[i]) begin
                failures++;
                $display("FAIL normal[%0d]: v=%b ieee=%h class=%h want 1/%h/%h",
                         i, io_out_valid, io_out_ieee, io_out_class,
                         ieee[i], cls[i]);
            end
        end
    endtask

    task automatic test_subnormal;
        logic [32:0] rec  [4] = '{33'h0_3580_0000, 33'h1_40C0_0000,
                                  33'h0_3500_0000, 33'h0_2000_0000};
        logic [31:0] ieee [4] = '{32'h0000_0001, 32'h8060_0000,
                                  32'h0000_0000, 32'h0000_0000};
        logic [9:0]  cls  [4] = '{10'h020, 10'h004, 10'h020, 10'h020};
        for (int i = 0; i < 4; i++) begin
            run_word(rec[i]);
            checks++;
            if (io_out_valid !== 1'b1 || io_out_ieee !== ieee[i]
                || io_out_class !== cls[i]) begin
                failures++;
                $display("FAIL subnorm[%0d]: v=%b ieee=%h class=%h want 1/%h/%h",
                         i, io_out_valid, io_out_ieee, io_out_class,
                         ieee[i], cls[i]);
            end
        end
    endtask

    task automatic test_specials;
        logic [32:0] rec  [6] = '{33'h1_C000_0000, 33'h0_C000_0000,
                                  33'h0_E040_0000, 33'h0_E000_0001,
                                  33'h1_0000_0000, 33'h0_0000_0000};
        logic [31:0] ieee [6] = '{32'hFF80_0000, 32'h7F80_0000,
                                  32'h7FC0_0000, 32'h7F80_0001,
                                  32'h8000_0000, 32'h0000_0000};
        logic [9:0]  cls  [6] = '{10'h001, 10'h080, 10'h200,
                                  10'h100, 10'h008, 10'h010};
        logic [3:0]  flg  [6] = '{4'b0101, 4'b0100, 4'b1000,
                                  4'b1000, 4'b0011, 4'b0010};
        for (int i = 0; i < 6; i++) begin
            run_word(rec[i]);
            checks++;
            if (io_out_valid !== 1'b1 || io_out_ieee !== ieee[i]
                || io_out_class !== cls[i]) begin
                failures++;
                $display("FAIL special[%0d]: v=%b ieee=%h class=%h want 1/%h/%h",
                         i, io_out_valid, io_out_ieee, io_out_class,
                         ieee[i], cls[i]);
            end
            checks++;
            if ({io_out_isNaN, io_out_isInf, io_out_isZero, io_out_sign}
                !== flg[i]) begin
                failures++;
                $display("FAIL special_flags[%0d]: got %b want %b", i,
                         {io_out_isNaN, io_out_isInf, io_out_isZero,
                          io_out_sign}, flg[i]);
            end
        end
        checks++;
        if (io_out_sig !== 27'h0 || io_out_sExp !== 10'h0) begin
            failures++;
            $display("FAIL zero_raw: sExp=%h sig=%h want 0/0",
                     io_out_sExp, io_out_sig);
        end
    endtask

    task automatic test_back_to_back;
        logic [32:0] rec  [4] = '{33'h0_8000_0000, 33'h0_3580_0000,
                                  33'h1_C000_0000, 33'h0_E040_0000};
        logic [31:0] ieee [4] = '{32'h3F80_0000, 32'h0000_0001,
                                  32'hFF80_0000, 32'h7FC0_0000};
        @(negedge clock);
        io_out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                checks++;
                if (io_out_valid !== 1'b1 || io_out_ieee !== ieee[c-2]) begin
                    failures++;
                    $display("FAIL b2b[%0d]: v=%b ieee=%h want 1/%h",
                             c - 2, io_out_valid, io_out_ieee, ieee[c-2]);
                end
            end
            io_in_valid = (c < 4);
            io_in_rec   = (c < 4) ? rec[c] : 33'h0;
            #1;
            if (c < 4) begin
                checks++;
                if (io_in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready[%0d]: got %b want 1",
                             c, io_in_ready);
                end
            end
            @(negedge clock);
        end
        checks++;
        if (io_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: valid=%b want 0", io_out_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [32:0] rec  [8] = '{33'h0_8000_0000, 33'h0_3580_0000,
                                  33'h0_BFFF_FFFF, 33'h1_C000_0000,
                                  33'h0_E040_0000, 33'h0_E000_0001,
                                  33'h1_0000_0000, 33'h1_40C0_0000};
        logic [31:0] ieee [8] = '{32'h3F80_0000, 32'h0000_0001,
                                  32'h7F7F_FFFF, 32'hFF80_0000,
                                  32'h7FC0_0000, 32'h7F80_0001,
                                  32'h8000_0000, 32'h8060_0000};
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        logic        stalled = 1'b0;
        logic [82:0] snap = '0;
        logic [82:0] now;
        while (got < 8 && cyc < 300) begin
            @(negedge clock);
            cyc++;
            now = {io_out_isNaN, io_out_isInf, io_out_isZero, io_out_sign,
                   io_out_sExp, io_out_sig, io_out_ieee, io_out_class};
            if (stalled) begin
                checks++;
                if (io_out_valid !== 1'b1 || now !== snap) begin
                    failures++;
                    $display("FAIL bp_stable: v=%b ieee=%h want 1/%h",
                             io_out_valid, io_out_ieee, snap[41:10]);
                end
            end
            io_out_ready = 1'($urandom_range(0, 1));
            io_in_valid  = (sent < 8) && ($urandom_range(0, 3) != 0);
            io_in_rec    = (sent < 8) ? rec[sent] : 33'h0;
            #1;
            checks++;
            if (io_in_ready !== ((sent - got) < 2 || io_out_ready)) begin
                failures++;
                $display("FAIL bp_ready: got %b want %b occ=%0d",
                         io_in_ready, (sent - got) < 2 || io_out_ready,
                         sent - got);
            end
            if (io_out_valid && io_out_ready) begin
                checks++;
                if (got >= sent || io_out_ieee !== ieee[got]) begin
                    failures++;
                    $display("FAIL bp_order[%0d]: ieee=%h want %h",
                             got, io_out_ieee, ieee[got]);
                end
                got++;
            end
            if (io_in_valid && io_in_ready)
                sent++;
            stalled = io_out_valid && !io_out_ready;
            snap    = {io_out_isNaN, io_out_isInf, io_out_isZero,
                       io_out_sign, io_out_sExp, io_out_sig, io_out_ieee,
                       io_out_class};
        end
        checks++;
        if (got != 8) begin
            failures++;
            $display("FAIL bp_timeout: delivered %0d want 8", got);
        end
        @(negedge clock);
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (io_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_dup: valid=%b want 0", io_out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        @(negedge clock);
        io_out_ready = 1'b0;
        io_in_valid  = 1'b1;
        io_in_rec    = 33'h0_8000_0000;
        @(negedge clock);
        io_in_rec    = 33'h0_C000_0000;
        @(negedge clock);
        io_in_valid  = 1'b0;
        #1;
        checks++;
        if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_full: v=%b ready=%b want 1/0",
                     io_out_valid, io_in_ready);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid: v=%b ready=%b want 0/1",
                     io_out_valid, io_in_ready);
        end
        @(negedge clock);
        reset = 1'b1;
        io_out_ready = 1'b1;
        io_in_valid  = 1'b1;
        io_in_rec    = 33'h0_E000_0001;
        @(negedge clock);
        io_in_valid  = 1'b0;
        checks++;
        if (io_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_after_early: valid=%b want 0", io_out_valid);
        end
        @(negedge clock);
        checks++;
        if (io_out_valid !== 1'b1 || io_out_ieee !== 32'h7F80_0001
            || io_out_class !== 10'h100) begin
            failures++;
            $display("FAIL rst_after: v=%b ieee=%h class=%h want 1/7f800001/100",
                     io_out_valid, io_out_ieee, io_out_class);
        end
        @(negedge clock);
        checks++;
        if (io_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_flush: valid=%b want 0", io_out_valid);
        end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_normal;
        test_subnormal;
        test_specials;
        test_back_to_back;
        test_backpressure;
        test_reset_midstream;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rec_fn_unpack_pipe.md
# rec_fn_unpack_pipe

Two-stage valid/ready pipeline that reads single-precision recoded floats (33-bit recFN) back out of the FPU. For each input it produces the raw fields in the same shape the rounding block consumes, the packed IEEE-754 binary32 word, and the RISC-V 10-bit fclass mask. It sits on the FPU result/store path: it is the unpack direction for recFN values written by the raw-to-recFN rounder.

## Interface
- EXP_W, 8: exponent width (fixed for this instance)
- SIG_W, 24: significand width including hidden bit (fixed)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- io_in_valid  in  1  input word valid
- io_in_ready  out  1  block accepts input this cycle
- io_in_rec  in  33  recFN {sign, exp[8:0], fract[22:0]}
- io_out_valid  out  1  output registers hold a result
- io_out_ready  in  1  consumer accepts output
- io_out_isNaN, io_out_isInf, io_out_isZero, io_out_sign  out  1 each  raw flags
- io_out_sExp  out  10  raw signed exponent
- io_out_sig  out  27  raw significand {0, hidden, fract, 2'b00}
- io_out_ieee  out  32  packed binary32
- io_out_class  out  10  fclass one-hot

## Operation
- Decode (stage 1), from exp[8:6]:
  - 000 → zero.
  - 110 → Inf.
  - 111 → NaN.
  - Otherwise finite nonzero.
- Raw fields:
  - sExp = {1'b0, exp}.
  - sig = {1'b0, !isZero, fract, 2'b00}.
  - Bit-identical to the rounder's raw input format.
- Subnormal when finite, nonzero and exp < 130.
- Pack (stage 2):
  - Zero: ieee = {sign, 31'b0}.
  - Inf: {sign, 8'hFF, 23'b0}.
  - NaN: {sign, 8'hFF, fract} with the payload passed unchanged.
  - Normal: {sign, (exp − 129)[7:0], fract}.
  - Subnormal: d = 130 − exp, range 1..24; fraction = ({1'b1, fract} >> d)[22:0]; exponent field 0.
  - Shift is logical; distances ≥ 24 yield 0 and must not wrap.
- fclass bits:
  - 0 −Inf, 1 −normal, 2 −subnormal, 3 −0.
  - 4 +0, 5 +subnormal, 6 +normal, 7 +Inf.
  - 8 sNaN (NaN, fract[22]=0), 9 qNaN (NaN, fract[22]=1).
  - Exactly one bit set for every input.
- Stage 1 registers the decoded fields and the subnormal shift distance.
- Stage 2 registers all outputs.

## Timing
- Latency: 2 cycles from input handshake to io_out_valid.
- Throughput: one word per cycle with io_out_ready held high.
- Handshakes:
  - Input handshake = io_in_valid & io_in_ready.
  - Output handshake = io_out_valid & io_out_ready.
- Stage advance rules:
  - Stage 2 loads when empty or when its output handshake fires.
  - Stage 1 advances into stage 2 under the same condition.
  - io_in_ready = !s1_valid | s2_load.
  - io_in_ready is combinational from io_out_ready; this path is permitted.
- Output stability: while io_out_valid=1 and io_out_ready=0, all io_out_* are held stable and no data is dropped. Two words buffer before io_in_ready falls.
- Simultaneous events: an output handshake and an input handshake in the same cycle both complete. The pipeline shifts with no bubble.
- Reset (async assert, sync deassert by the system):
  - s1_valid, s2_valid = 0; io_out_valid = 0; io_in_ready = 1.
  - Data registers = 0, so io_out_class and io_out_ieee = 0.
- Reset mid-operation discards all in-flight words. The first handshake after release behaves as from empty.
- Data registers do not update when their stage does not load; no spurious toggling.

## Structure
- Shared package rec_fn_pkg holds:
  - EXP_W, SIG_W, MIN_NORM_EXP = 130, EXP_BIAS_ADJ = 129.
  - Recoded exponent codes: ZERO = 3'b000, INF = 3'b110, NaN = 3'b111.
  - fclass bit-index constants.
  - A packed raw-float struct {isNaN, isInf, isZero, sign, sExp[9:0], sig[26:0]}, shared with the rounder interface.
- Sub-module rec_fn_decode: purely combinational recFN → raw struct + subnormal flag + shift distance.
- Top level holds the two pipeline stages, the handshake logic and the stage-2 packer.

## Test plan
- 1.0: io_in_rec=33'h0_8000_0000 → after 2 cycles: ieee 32'h3F80_0000, sExp 10'h100, sig 27'h200_0000, class 10'h040.
- Min subnormal: 33'h0_3580_0000 → ieee 32'h0000_0001, class 10'h020. Max normal: 33'h0_BFFF_FFFF → ieee 32'h7F7F_FFFF.
- Specials:
  - 33'h1_C000_0000 → ieee 32'hFF80_0000, class 10'h001.
  - 33'h0_E040_0000 → 32'h7FC0_0000, class 10'h200.
  - 33'h0_E000_0001 → 32'h7F80_0001, class 10'h100.
  - 33'h1_0000_0000 → 32'h8000_0000, class 10'h008.
- Backpressure: stream 8 words with io_out_ready toggling randomly. Require:
  - Outputs arrive in order with no loss or duplication.
  - Outputs are stable while stalled.
  - io_in_ready=0 only when both stages are full.
- Reset mid-stream: assert reset with 2 words in flight. Require io_out_valid=0 immediately and io_in_ready=1. After release, the next word emerges 2 cycles after its handshake.
